cordic_fp_seq: RTL and testbench



---
 rtl/cordic_fp_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_cordic_fp_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_fp_seq.sv
// cordic_fp_seq: rotation-mode CORDIC on single-precision floats.
// Build option CORDIC_GAIN_COMP_EN: preload x with 1/gain, y with 0.

module fpu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        control,
  output logic [31:0] result
);
  logic [31:0]       bx, p, q;
  logic              sub, st, rs;
  logic [7:0]        d;
  logic [4:0]        ds, lz;
  logic [26:0]       pm, qm, qs, n;
  logic [53:0]       qw;
  logic [27:0]       s;
  logic signed [9:0] e;
  logic [24:0]       r;
  logic [22:0]       frac;

  // align, add/sub, normalise, round to nearest even
  always_comb begin
    bx = {b[31] ^ control, b[30:0]};
    if (a[30:0] >= bx[30:0]) begin
      p = a;
      q = bx;
    end else begin
      p = bx;
      q = a;
    end
    sub = p[31] ^ q[31];
    d   = p[30:23] - q[30:23];
    ds  = (d > 8'd31) ? 5'd31 : d[4:0];
    pm  = (p[30:23] == 8'd0) ? 27'b0 : {1'b1, p[22:0], 3'b0};
    qm  = (q[30:23] == 8'd0) ? 27'b0 : {1'b1, q[22:0], 3'b0};
    qw  = {qm, 27'b0} >> ds;
    st  = |qw[26:0];
    qs  = {qw[53:28], qw[27] | st};
    s   = sub ? ({1'b0, pm} - {1'b0, qs})
              : ({1'b0, pm} + {1'b0, qs});
    lz  = 5'd0;
    for (int k = 0; k < 27; k++)
      if (s[k]) lz = 5'(26 - k);
    e = signed'({2'b0, p[30:23]});
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = e + 10'sd1;
    end else begin
      n = s[26:0] << lz;
      e = e - signed'({5'b0, lz});
    end
    rs = n[2] & (n[1] | n[0] | n[3]);
    r  = {1'b0, n[26:3]} + {24'b0, rs};
    frac = r[24] ? r[23:1] : r[22:0];
    if (r[24]) e = e + 10'sd1;
    if (p[30:23] == 8'hFF)
      result = p;
    else if (s == 28'd0)
      result = {~sub & p[31], 31'b0};
    else if (e <= 10'sd0)
      result = {p[31], 31'b0};
    else if (e >= 10'sd255)
      result = {p[31], 8'hFF, 23'b0};
    else
      result = {p[31], e[7:0], frac};
  end
endmodule

module cordic_fp_seq #(
  parameter int ITERS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] z_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] z_out
);
  typedef enum logic [2:0] {
    IDLE, ITX, ITY, ITZ, FIN
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  i;
  logic [31:0] x, y, z, x_tmp, y_tmp;
  logic [31:0] x0, y0, atan;
  logic [31:0] fa, fb, fr;
  logic        fc, dir, last;

`ifdef CORDIC_GAIN_COMP_EN
  assign x0 = 32'h3F1B74EE;
  assign y0 = 32'h0;
`else
  assign x0 = x_in;
  assign y0 = y_in;
`endif

  assign dir  = z[31];
  assign last = (i == 5'(ITERS - 1));

  // divide by 2^s by lowering the exponent
  function automatic logic [31:0] sh(
    input logic [31:0] v,
    input logic [4:0]  s
  );
    if (v[30:23] == 8'hFF)
      return v;
    else if (v[30:23] <= {3'b0, s})
      return {v[31], 31'b0};
    else
      return {v[31], v[30:23] - {3'b0, s}, v[22:0]};
  endfunction

  // arctangent ROM, atan(2^-i) rounded to nearest
  always_comb begin
    atan = 32'h0;
    case (i)
      5'd0:  atan = 32'h3F490FDB;
      5'd1:  atan = 32'h3EED6338;
      5'd2:  atan = 32'h3E7ADBB0;
      5'd3:  atan = 32'h3DFEADD5;
      5'd4:  atan = 32'h3D7FAADE;
      5'd5:  atan = 32'h3CFFEAAE;
      5'd6:  atan = 32'h3C7FFAAB;
      5'd7:  atan = 32'h3BFFFEAB;
      5'd8:  atan = 32'h3B7FFFAB;
      5'd9:  atan = 32'h3AFFFFEB;
      5'd10: atan = 32'h3A7FFFFB;
      5'd11: atan = 32'h39FFFFFF;
      5'd12: atan = 32'h39800000;
      5'd13: atan = 32'h39000000;
      5'd14: atan = 32'h38800000;
      5'd15: atan = 32'h38000000;
      5'd16: atan = 32'h37800000;
      5'd17: atan = 32'h37000000;
      5'd18: atan = 32'h36800000;
      5'd19: atan = 32'h36000000;
      5'd20: atan = 32'h35800000;
      5'd21: atan = 32'h35000000;
      5'd22: atan = 32'h34800000;
      5'd23: atan = 32'h34000000;
      default: atan = 32'h0;
    endcase
  end

  // steer the shared adder to the x, y or z update
  always_comb begin
    fa = x;
    fb = sh(y, i);
    fc = ~dir;
    unique case (1'b1)
      (state == ITY): begin
        fa = y;
        fb = sh(x, i);
        fc = dir;
      end
      (state == ITZ): begin
        fa = z;
        fb = atan;
        fc = ~dir;
      end
      default: ;
    endcase
  end

  fpu u_fpu (
    .a       (fa),
    .b       (fb),
    .control (fc),
    .result  (fr)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITX;
      ITX:     state_nxt = ITY;
      ITY:     state_nxt = ITZ;
      ITZ:     state_nxt = last ? FIN : ITX;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  // datapath; final results land together with done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i     <= 5'd0;
      x     <= 32'h0;
      y     <= 32'h0;
      z     <= 32'h0;
      x_tmp <= 32'h0;
      y_tmp <= 32'h0;
      x_out <= 32'h0;
      y_out <= 32'h0;
      z_out <= 32'h0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x <= x0;
          y <= y0;
          z <= z_in;
          i <= 5'd0;
        end
        ITX: x_tmp <= fr;
        ITY: y_tmp <= fr;
        ITZ: begin
          z <= fr;
          x <= x_tmp;
          y <= y_tmp;
          i <= i + 5'd1;
          if (last) begin
            x_out <= x_tmp;
            y_out <= y_tmp;
            z_out <= fr;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_fp_seq.sv
// tb_cordic_fp_seq: directed checks of timing, accuracy and control.
// Float results are compared within an absolute tolerance.
`timescale 1ns/1ps
module tb_cordic_fp_seq;
  logic        clk = 1'b0;
  logic        rst_n, start, busy, done;
  logic [31:0] x_in, y_in, z_in, x_out, y_out, z_out;
  int          checks = 0;
  int          failures = 0;
  int          dn, n;

  always #5 clk = ~clk;

  cordic_fp_seq #(.ITERS(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .busy  (busy),
    .done  (done),
    .x_out (x_out),
    .y_out (y_out),
    .z_out (z_out)
  );

  function automatic real f2r(input logic [31:0] v);
    real m;
    int  ex;
    if (v[30:23] == 8'd0) return 0.0;
    m  = 1.0 + real'(v[22:0]) / 8388608.0;
    ex = int'(v[30:23]) - 127;
    while (ex > 0) begin m = m * 2.0; ex--; end
    while (ex < 0) begin m = m / 2.0; ex++; end
    return v[31] ? -m : m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, want);
    end
  endtask

  task automatic near(input string tag, input logic [31:0] obs,
                      input real want, input real tol);
    real  a;
    logic ok;
    a  = f2r(obs);
    ok = ((a - want) < tol) && ((want - a) < tol);
    checks++;
    assert (ok === 1'b1) else begin
      failures++;
      $error("FAIL %s obs=%h (%f) exp=%f tol=%g", tag, obs, a, want, tol);
    end
  endtask

  // one transaction from IDLE; checks start-to-done latency
  task automatic go(input logic [31:0] xi, input logic [31:0] yi,
                    input logic [31:0] zi, input string tag);
    int c;
    @(negedge clk);
    x_in = xi; y_in = yi; z_in = zi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (done !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_lat"}, 32'(c), 32'd73);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    x_in = 32'h0; y_in = 32'h0; z_in = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_x", x_out, 32'h0);
    chk("rst_y", y_out, 32'h0);
    chk("rst_z", z_out, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // timing: x=1, y=0, z=0
    x_in = 32'h3F800000; y_in = 32'h0; z_in = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t_busy1", {31'b0, busy}, 32'd1);
    chk("t_done1", {31'b0, done}, 32'd0);
    dn = 0;
    for (int c = 2; c <= 72; c++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("t_early_done", 32'(dn), 32'd0);
    @(negedge clk);
    chk("t_done73", {31'b0, done}, 32'd1);
    chk("t_busy73", {31'b0, busy}, 32'd1);
`ifdef CORDIC_GAIN_COMP_EN
    near("gain_x", x_out, 1.0, 1e-5);
`else
    near("gain_x", x_out, 1.6467603, 1e-5);
`endif
    near("gain_y", y_out, 0.0, 1e-5);
    near("gain_z", z_out, 0.0, 1e-6);
    @(negedge clk);
    chk("t_done74", {31'b0, done}, 32'd0);
    chk("t_busy74", {31'b0, busy}, 32'd0);

    // pi/6 starting from 1/gain
    go(32'h3F1B74EE, 32'h0, 32'h3F060A92, "pi6");
    near("pi6_x", x_out, 0.8660254, 4e-6);
    near("pi6_y", y_out, 0.5, 4e-6);
    near("pi6_z", z_out, 0.0, 1e-6);
    x_in = 32'h40000000; y_in = 32'h3F800000; z_in = 32'hBF000000;
    repeat (10) @(negedge clk);
    near("hold_x", x_out, 0.8660254, 4e-6);
    near("hold_y", y_out, 0.5, 4e-6);

    // -pi/4
    go(32'h3F1B74EE, 32'h0, 32'hBF490FDB, "npi4");
    near("npi4_x", x_out, 0.7071068, 4e-6);
    near("npi4_y", y_out, -0.7071068, 4e-6);
    chk("npi4_ysign", {31'b0, y_out[31]}, 32'd1);

`ifndef CORDIC_GAIN_COMP_EN
    // y at smallest normal: its shifted copy flushes to zero from i=1
    @(negedge clk);
    x_in = 32'h0; y_in = 32'h00800000; z_in = 32'h0; start = 1'b1;
    for (int c = 1; c <= 73; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c >= 5 && (c % 3) == 2)
        chk($sformatf("flush_i%0d", (c - 2) / 3), dut.x_tmp, 32'h80800000);
    end
    chk("flush_xo", x_out, 32'h80800000);
    chk("flush_yo", y_out, 32'h00800000);
`endif

    // start held through busy and FIN, then one more cycle
    @(negedge clk);
    x_in = 32'h3F800000; y_in = 32'h0; z_in = 32'h0; start = 1'b1;
    dn = 0;
    for (int c = 1; c <= 74; c++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("held_dones", 32'(dn), 32'd1);
    chk("held_busy74", {31'b0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("held_busy75", {31'b0, busy}, 32'd1);
    n = 75;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("held_redone", 32'(n), 32'd147);

    // reset mid-computation
    @(negedge clk);
    x_in = 32'h3F1B74EE; y_in = 32'h0; z_in = 32'h3F060A92; start = 1'b1;
    dn = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dn++;
      if (c == 30) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    if (done === 1'b1) dn++;
    chk("abort_dones", 32'(dn), 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_x", x_out, 32'h0);
    chk("abort_y", y_out, 32'h0);
    chk("abort_z", z_out, 32'h0);
    chk("abort_i", {27'b0, dut.i}, 32'd0);
    go(32'h3F1B74EE, 32'h0, 32'h3F060A92, "restart");
    near("restart_x", x_out, 0.8660254, 4e-6);
    near("restart_y", y_out, 0.5, 4e-6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
